softmax_job_sched: RTL and testbench
====================================

SOFTMAX_JOB_SCHED -- requirements
Module: softmax_job_sched

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 8: width of engine start/end addresses.
REQ-002 SHALL have parameter TAG_W, default 4: job tag width.
REQ-003 SHALL have parameter DEPTH, default 4: job FIFO entries, power of two.
REQ-004 SHALL have parameter TIMEOUT, default 1024: max RUN cycles before abort.
REQ-005 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have ports job_valid (input, 1) and job_ready (output, 1): job descriptor handshake.
REQ-008 SHALL have ports job_start_addr and job_end_addr (input, ADDRSIZE each) and job_tag (input, TAG_W): descriptor fields.
REQ-009 SHALL have ports sm_init (output, 1), sm_start (output, 1), sm_start_addr (output, ADDRSIZE), sm_end_addr (output, ADDRSIZE): softmax engine control.
REQ-010 SHALL have port sm_done, input, 1: engine completion pulse.
REQ-011 SHALL have port sm_reset, output, 1: engine abort pulse.
REQ-012 SHALL have ports cmp_valid (output, 1), cmp_ready (input, 1), cmp_tag (output, TAG_W), cmp_err (output, 1): completion handshake.
REQ-013 SHALL have port busy, output, 1: high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-014 SHALL buffer descriptors in a DEPTH-entry FIFO; job_ready = not full; a write occurs when job_valid and job_ready are both high at a clock edge.
REQ-015 SHALL NOT provide a full-FIFO bypass; a push while full is impossible because job_ready is low.
REQ-016 SHALL implement FSM states IDLE, INIT, START, RUN, CPL.
REQ-017 IDLE: when the FIFO is non-empty, SHALL pop the head into current registers (start, end, tag); next state is INIT if end > start, else CPL with cmp_err=1.
REQ-018 INIT: SHALL assert sm_init for exactly 1 cycle; next state START.
REQ-019 START: SHALL assert sm_start for exactly 1 cycle and clear the timeout counter; next state RUN.
REQ-020 sm_start_addr and sm_end_addr SHALL equal the current registers, held stable from INIT through the end of RUN; they SHALL be 0 in IDLE.
REQ-021 RUN: SHALL increment the timeout counter each cycle.
REQ-022 RUN: on sm_done SHALL go to CPL with cmp_err=0.
REQ-023 RUN: when the counter reaches TIMEOUT-1 without sm_done, SHALL pulse sm_reset for 1 cycle and go to CPL with cmp_err=1.
REQ-024 If sm_done and the timeout coincide, sm_done SHALL win: cmp_err=0, no sm_reset.
REQ-025 sm_done outside RUN SHALL be ignored.
REQ-026 CPL: SHALL hold cmp_valid=1 with cmp_tag and cmp_err stable until cmp_ready is high at an edge, then go to IDLE.
REQ-027 The FIFO SHALL keep accepting jobs in every state.
REQ-028 Latency: for a job written into an empty FIFO at edge N with the FSM in IDLE, sm_init SHALL be high in the cycle after edge N+1 and sm_start in the cycle after edge N+2.
REQ-029 Back-to-back: after a CPL handshake at edge M with the FIFO non-empty, sm_init SHALL be high in the cycle after edge M+1.
REQ-030 Jobs SHALL complete strictly in FIFO order; exactly one completion per accepted job.

Reset
REQ-031 Reset SHALL take priority over all other inputs in the same cycle.
REQ-032 On reset: FSM to IDLE, FIFO emptied, counter 0, all outputs 0 (sm_*, cmp_*, busy) except job_ready, which is 1.
REQ-033 Reset mid-RUN or mid-CPL SHALL discard the in-flight job and all queued jobs with no completion issued, and SHALL NOT pulse sm_reset.

Verification
REQ-034 Job (start=2, end=10, tag=3) into idle block at edge N, with sm_done 12 cycles after sm_start and cmp_ready=1 -> sm_init in cycle N+2, sm_start in cycle N+3, sm_start_addr=2 and sm_end_addr=10 held through RUN, cmp_valid with tag=3, err=0.
REQ-035 Push 5 jobs with the engine stalled -> job_ready low after 4 accepted; 5th accepted after the first pop; completions in order with tags 0-4.
REQ-036 Job with start=8, end=8 -> no sm_init or sm_start, cmp_valid with err=1 two cycles after push.
REQ-037 TIMEOUT=16, sm_done never asserted -> sm_reset pulse 16 cycles after sm_start, cmp_err=1; next job proceeds normally.
REQ-038 cmp_ready low for 5 cycles in CPL -> cmp_valid, cmp_tag, cmp_err stable; no new sm_init until the handshake.
REQ-039 Reset asserted during RUN with 2 jobs queued -> next cycle busy=0, job_ready=1, cmp_valid=0; late sm_done ignored.

Source files
------------

// File: rtl/softmax_job_sched_if.sv
// Signal bundle of the softmax job scheduler: job intake, engine control and completion.
// The slave modport is the scheduler. The master modport is the job source, the engine and the completion sink.
interface softmax_job_sched_if #(
    parameter int ADDRSIZE = 8,
    parameter int TAG_W    = 4
);
    logic                job_valid;
    logic                job_ready;
    logic [ADDRSIZE-1:0] job_start_addr;
    logic [ADDRSIZE-1:0] job_end_addr;
    logic [TAG_W-1:0]    job_tag;
    logic                sm_init;
    logic                sm_start;
    logic [ADDRSIZE-1:0] sm_start_addr;
    logic [ADDRSIZE-1:0] sm_end_addr;
    logic                sm_done;
    logic                sm_reset;
    logic                cmp_valid;
    logic                cmp_ready;
    logic [TAG_W-1:0]    cmp_tag;
    logic                cmp_err;
    logic                busy;

    modport slave (
        input  job_valid, job_start_addr, job_end_addr, job_tag, sm_done, cmp_ready,
        output job_ready, sm_init, sm_start, sm_start_addr, sm_end_addr, sm_reset,
               cmp_valid, cmp_tag, cmp_err, busy
    );

    modport master (
        output job_valid, job_start_addr, job_end_addr, job_tag, sm_done, cmp_ready,
        input  job_ready, sm_init, sm_start, sm_start_addr, sm_end_addr, sm_reset,
               cmp_valid, cmp_tag, cmp_err, busy
    );
endinterface

// File: rtl/softmax_job_sched.sv
// Softmax job scheduler: queues job descriptors and runs them one at a time on the engine.
// Each job ends in exactly one completion. The completion flags an empty address range or a run that timed out.
module softmax_job_sched #(
    parameter int ADDRSIZE = 8,
    parameter int TAG_W    = 4,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               reset,
    softmax_job_sched_if.slave bus
);
    // DEPTH is a power of two and at least 2.
    localparam int PTR_W = $clog2(DEPTH);
    // TIMEOUT must be at least 2.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [ADDRSIZE-1:0] start_addr;
        logic [ADDRSIZE-1:0] end_addr;
        logic [TAG_W-1:0]    tag;
    } job_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        CPL   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    job_t             r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    job_t             r_cur;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    job_t             w_in;
    job_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_timeout;
    logic             w_active;

    assign w_in    = {bus.job_start_addr, bus.job_end_addr, bus.job_tag};
    assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
    // The extra pointer bit tells a full FIFO from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = bus.job_valid && !w_full;

    // Descriptor storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_in;
        end
    end

    // FIFO write/read pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state, FIFO pop and timeout detection; sm_done beats a coinciding timeout
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head.end_addr > w_head.start_addr) begin
                        w_state_nxt = INIT;
                    end else begin
                        w_state_nxt = CPL;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            INIT:  w_state_nxt = START;
            START: w_state_nxt = RUN;
            RUN: begin
                if (bus.sm_done) begin
                    w_state_nxt = CPL;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = CPL;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            CPL: begin
                if (bus.cmp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = CPL;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Current job, completion error flag and run-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_cur <= w_head;
                r_err <= !(w_head.end_addr > w_head.start_addr);
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (r_state == START) begin
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_active          = (r_state == INIT) || (r_state == START) || (r_state == RUN);
    assign bus.job_ready     = !w_full;
    assign bus.sm_init       = (r_state == INIT);
    assign bus.sm_start      = (r_state == START);
    assign bus.sm_start_addr = w_active ? r_cur.start_addr : '0;
    assign bus.sm_end_addr   = w_active ? r_cur.end_addr : '0;
    // A reset arriving in the timeout cycle discards the job silently instead of aborting the engine.
    assign bus.sm_reset      = w_timeout && !reset;
    assign bus.cmp_valid     = (r_state == CPL);
    assign bus.cmp_tag       = (r_state == CPL) ? r_cur.tag : '0;
    assign bus.cmp_err       = (r_state == CPL) && r_err;
    assign bus.busy          = (r_state != IDLE) || !w_empty;
endmodule

// File: tb/tb_softmax_job_sched.sv
// Self-checking bench for softmax_job_sched. A job-timeline model is compared against the DUT every cycle.
// Directed scenarios add hand-computed latency, ordering and reset checks.
module tb_softmax_job_sched;
    localparam int ADDRSIZE = 8;
    localparam int TAG_W    = 4;
    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    softmax_job_sched_if #(.ADDRSIZE(ADDRSIZE), .TAG_W(TAG_W)) bus();

    softmax_job_sched #(
        .ADDRSIZE(ADDRSIZE), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic man_done  = 1'b0;
    logic auto_done = 1'b0;
    bit   auto_en   = 1'b0;
    int   ad_cnt    = -1;
    assign bus.sm_done = man_done | auto_done;

    // Engine stand-in: when enabled, sm_done rises three cycles after each sm_start
    always @(posedge clk) begin
        #1;
        auto_done = 1'b0;
        if (ad_cnt == 0) begin
            auto_done = 1'b1;
            ad_cnt = -1;
        end else if (ad_cnt > 0) begin
            ad_cnt--;
        end
        if (auto_en && bus.sm_start) ad_cnt = 2;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: pending queue plus the age of the job in flight (1 = init, 2 = start, >=3 = run)
    typedef struct { int s; int e; int t; } mjob_t;
    mjob_t m_q[$];
    mjob_t m_cur;
    bit    m_act = 1'b0;
    bit    m_cpl = 1'b0;
    bit    m_err = 1'b0;
    int    m_age = 0;
    bit    chk_en = 1'b0;

    int init_q[$];
    int log_tag[$];
    int log_err[$];
    int log_edge[$];
    int start_cyc = -1, rst_cyc = -1, cv_rise_cyc = -1, n_rst = 0;
    int sa_at_start = -1, ea_at_start = -1;
    bit prev_cv = 1'b0;

    // Per-cycle compare, event log and model advance, all mid-cycle
    always @(negedge clk) begin
        bit e_init, e_start, e_run, e_cv, rdy;
        int e_sa, e_ea;
        e_init  = m_act && !m_cpl && (m_age == 1);
        e_start = m_act && !m_cpl && (m_age == 2);
        e_run   = m_act && !m_cpl && (m_age >= 3);
        e_cv    = m_act && m_cpl;
        rdy     = (m_q.size() < DEPTH);
        e_sa    = (m_act && !m_cpl) ? m_cur.s : 0;
        e_ea    = (m_act && !m_cpl) ? m_cur.e : 0;
        if (chk_en) begin
            chk1("job_ready", bus.job_ready, rdy);
            chk1("busy", bus.busy, m_act || (m_q.size() != 0));
            chk1("sm_init", bus.sm_init, e_init);
            chk1("sm_start", bus.sm_start, e_start);
            chk1("sm_reset", bus.sm_reset,
                 e_run && !bus.sm_done && (m_age == TIMEOUT + 2) && !reset);
            chk1("cmp_valid", bus.cmp_valid, e_cv);
            if (e_cv) begin
                chkw("cmp_tag", int'(bus.cmp_tag), m_cur.t);
                chk1("cmp_err", bus.cmp_err, m_err);
            end else begin
                chkw("sm_start_addr", int'(bus.sm_start_addr), e_sa);
                chkw("sm_end_addr", int'(bus.sm_end_addr), e_ea);
            end
            if (bus.sm_init) init_q.push_back(cyc);
            if (bus.sm_start) begin
                start_cyc   = cyc;
                sa_at_start = int'(bus.sm_start_addr);
                ea_at_start = int'(bus.sm_end_addr);
            end
            if (bus.sm_reset) begin
                n_rst++;
                rst_cyc = cyc;
            end
            if (bus.cmp_valid && !prev_cv) cv_rise_cyc = cyc;
            if (bus.cmp_valid && bus.cmp_ready && !reset) begin
                log_tag.push_back(int'(bus.cmp_tag));
                log_err.push_back(int'(bus.cmp_err));
                log_edge.push_back(cyc + 1);
            end
            prev_cv = bus.cmp_valid;
        end
        if (reset) begin
            m_q.delete();
            m_act = 1'b0;
            m_cpl = 1'b0;
            m_err = 1'b0;
            m_age = 0;
        end else begin
            if (m_act) begin
                if (m_cpl) begin
                    if (bus.cmp_ready) m_act = 1'b0;
                end else if (e_run && bus.sm_done) begin
                    m_cpl = 1'b1;
                    m_err = 1'b0;
                end else if (e_run && (m_age == TIMEOUT + 2)) begin
                    m_cpl = 1'b1;
                    m_err = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (m_q.size() != 0) begin
                m_cur = m_q.pop_front();
                m_act = 1'b1;
                m_age = 1;
                m_cpl = !(m_cur.e > m_cur.s);
                m_err = m_cpl;
            end
            if (bus.job_valid && rdy) begin
                m_q.push_back('{int'(bus.job_start_addr), int'(bus.job_end_addr), int'(bus.job_tag)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one descriptor until accepted; edge_n is the accepting edge
    task automatic push_job(input int s, input int e, input int t, output int edge_n);
        bus.job_start_addr = ADDRSIZE'(s);
        bus.job_end_addr   = ADDRSIZE'(e);
        bus.job_tag        = TAG_W'(t);
        bus.job_valid      = 1'b1;
        edge_n = -1;
        for (int k = 0; k < 100 && edge_n < 0; k++) begin
            @(negedge clk);
            if (bus.job_ready) edge_n = cyc + 1;
            tick();
        end
        bus.job_valid = 1'b0;
        if (edge_n < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_bound: tag %0d never accepted", t);
        end
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int k = 0; k < 100 && s < 0; k++) begin
            @(negedge clk);
            if (bus.sm_start) s = cyc;
            tick();
        end
        if (s < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL start_bound: no sm_start within 100 cycles");
        end
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 200 && log_tag.size() < n; k++) tick();
        chkw("completion_count", log_tag.size(), n);
    endtask

    task automatic done_at(input int c);
        while (cyc < c) tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
    endtask

    initial begin
        int n_edge, s_cyc, p5, n0, i0, r0;
        bus.job_valid      = 1'b0;
        bus.job_start_addr = '0;
        bus.job_end_addr   = '0;
        bus.job_tag        = '0;
        bus.cmp_ready      = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk1("rst_job_ready", bus.job_ready, 1'b1);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_cmp_valid", bus.cmp_valid, 1'b0);
        chk1("rst_sm_init", bus.sm_init, 1'b0);
        tick();

        // Nominal job: init one cycle after the pop edge, done 12 cycles after start
        push_job(2, 10, 3, n_edge);
        wait_start(s_cyc);
        chkw("t1_init_cyc", init_q[0], n_edge + 1);
        chkw("t1_start_cyc", s_cyc, n_edge + 2);
        chkw("t1_start_addr", sa_at_start, 2);
        chkw("t1_end_addr", ea_at_start, 10);
        done_at(s_cyc + 12);
        wait_log(1);
        chkw("t1_cpl_rise", cv_rise_cyc, s_cyc + 13);
        chkw("t1_tag", log_tag[0], 3);
        chkw("t1_err", log_err[0], 0);

        // Empty range: straight to completion with error, engine untouched
        i0 = init_q.size();
        push_job(8, 8, 5, n_edge);
        wait_log(2);
        chkw("t2_cpl_rise", cv_rise_cyc, n_edge + 1);
        chkw("t2_tag", log_tag[1], 5);
        chkw("t2_err", log_err[1], 1);
        chkw("t2_no_init", init_q.size(), i0);

        // Timeout after 16 run cycles, then a normal job
        r0 = n_rst;
        push_job(0, 4, 6, n_edge);
        wait_start(s_cyc);
        wait_log(3);
        chkw("t3_rst_cyc", rst_cyc, s_cyc + 16);
        chkw("t3_rst_cnt", n_rst, r0 + 1);
        chkw("t3_tag", log_tag[2], 6);
        chkw("t3_err", log_err[2], 1);
        push_job(1, 3, 7, n_edge);
        wait_start(s_cyc);
        done_at(s_cyc + 2);
        wait_log(4);
        chkw("t3b_tag", log_tag[3], 7);
        chkw("t3b_err", log_err[3], 0);

        // sm_done in the timeout cycle wins
        r0 = n_rst;
        push_job(0, 2, 8, n_edge);
        wait_start(s_cyc);
        done_at(s_cyc + 16);
        wait_log(5);
        chkw("t6_tag", log_tag[4], 8);
        chkw("t6_err", log_err[4], 0);
        chkw("t6_no_sm_reset", n_rst, r0);

        // Completion stall fills the FIFO; fifth job enters after the first pop
        bus.cmp_ready = 1'b0;
        auto_en = 1'b1;
        push_job(5, 5, 9, n_edge);
        for (int i = 0; i < 4; i++) push_job(i, i + 5, i, n_edge);
        @(negedge clk);
        chk1("t4_full_ready", bus.job_ready, 1'b0);
        chk1("t4_stall_valid", bus.cmp_valid, 1'b1);
        chkw("t4_stall_tag", int'(bus.cmp_tag), 9);
        i0 = init_q.size();
        tick();
        fork
            push_job(4, 9, 4, p5);
            begin
                repeat (5) tick();
                chkw("t4_no_init_stall", init_q.size(), i0);
                bus.cmp_ready = 1'b1;
            end
        join
        wait_log(11);
        chkw("t4_blk_tag", log_tag[5], 9);
        chkw("t4_blk_err", log_err[5], 1);
        chkw("t4_b2b_init", init_q[4], log_edge[5] + 1);
        chkw("t4_fifth_edge", p5, log_edge[5] + 2);
        for (int i = 0; i < 5; i++) begin
            chkw("t4_order_tag", log_tag[6 + i], i);
            chkw("t4_order_err", log_err[6 + i], 0);
        end

        // Reset mid-run with two jobs queued discards everything
        auto_en = 1'b0;
        push_job(0, 9, 1, n_edge);
        push_job(0, 9, 2, n_edge);
        push_job(0, 9, 3, n_edge);
        wait_start(s_cyc);
        tick();
        n0 = log_tag.size();
        i0 = init_q.size();
        r0 = n_rst;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk1("t5_busy", bus.busy, 1'b0);
        chk1("t5_job_ready", bus.job_ready, 1'b1);
        chk1("t5_cmp_valid", bus.cmp_valid, 1'b0);
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (20) tick();
        chkw("t5_no_completion", log_tag.size(), n0);
        chkw("t5_no_init", init_q.size(), i0);
        chkw("t5_no_sm_reset", n_rst, r0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end
endmodule
